scan_reg_bank: RTL

//  Parametrised multi-bit mux-D scan register bank: WIDTH scan flops sharing one clock,
//  an async active-low reset, a functional load enable, and CHAINS independent scan chains.

---
 rtl/scan_reg_bank_if.sv | 23 ++
 rtl/scan_reg_bank.sv | 100 ++++++++++
 2 files changed

// File: rtl/scan_reg_bank_if.sv
// Bus bundle for scan_reg_bank: functional/scan controls and data in,
// register contents, scan-out and shift-progress status out.
//   master : drives SE, E, D, SI; observes Q, SO, SHIFT_CNT, SHIFT_DONE
//   slave  : the register bank itself
interface scan_reg_bank_if #(
    parameter int WIDTH  = 8,
    parameter int CHAINS = 1
);
    localparam int L     = WIDTH / CHAINS;
    localparam int CNT_W = $clog2(L + 1);

    logic              SE;
    logic              E;
    logic [WIDTH-1:0]  D;
    logic [CHAINS-1:0] SI;
    logic [WIDTH-1:0]  Q;
    logic [CHAINS-1:0] SO;
    logic [CNT_W-1:0]  SHIFT_CNT;
    logic              SHIFT_DONE;

    modport master (output SE, E, D, SI, input Q, SO, SHIFT_CNT, SHIFT_DONE);
    modport slave  (input SE, E, D, SI, output Q, SO, SHIFT_CNT, SHIFT_DONE);
endinterface

// File: rtl/scan_reg_bank.sv
// Mux-D scan register bank with CHAINS parallel scan chains.
//   CLK  : rising-edge clock
//   RN   : asynchronous active-low reset (Q=RESET_VAL, counter cleared)
//   bus  : scan_reg_bank_if.slave
//          SE scan enable (priority over E), E load enable, D functional data,
//          SI per-chain scan-in, Q contents, SO per-chain scan-out,
//          SHIFT_CNT shifts done modulo L, SHIFT_DONE pulse after each L-th shift.
// Chain c owns Q[c*L +: L]; head bit c*L takes SI[c], tail bit c*L+L-1 feeds SO[c].
module scan_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CHAINS    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               LOCKUP    = 1'b1
) (
    input  logic            CLK,
    input  logic            RN,
    scan_reg_bank_if.slave  bus
);
    localparam int L     = WIDTH / CHAINS;
    localparam int CNT_W = $clog2(L + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(L - 1);

    generate
        if (WIDTH < 1 || CHAINS < 1 || (WIDTH % CHAINS) != 0) begin : g_param_err
            $fatal(1, "scan_reg_bank: CHAINS must divide WIDTH and both must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  shift_v;
    logic [CHAINS-1:0] tail;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    // Shifted image of the register: each chain moves one place toward its tail.
    genvar c, i;
    generate
        for (c = 0; c < CHAINS; c++) begin : g_chain
            for (i = 0; i < L; i++) begin : g_bit
                if (i == 0) begin : g_head
                    assign shift_v[c*L] = bus.SI[c];
                end else begin : g_body
                    assign shift_v[c*L+i] = q_q[c*L+i-1];
                end
            end

            assign tail[c] = q_q[c*L+L-1];

            if (LOCKUP) begin : g_lockup
                // Negative-level latch: SO moves half a cycle after the tail
                // flop, so a downstream chain on a late clock still sees the
                // old bit at its own edge.
                logic so_lat;
                always_latch begin
                    if (!RN)
                        so_lat <= RESET_VAL[c*L+L-1];
                    else if (!CLK)
                        so_lat <= tail[c];
                end
                assign bus.SO[c] = so_lat;
            end else begin : g_direct
                assign bus.SO[c] = tail[c];
            end
        end
    endgenerate

    always_comb begin
        q_d    = q_q;
        cnt_d  = '0;
        done_d = 1'b0;
        if (bus.SE) begin
            q_d = shift_v;
            // Wrap at L-1 and flag a completed full-chain shift.
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.E) begin
            q_d = bus.D;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.Q          = q_q;
    assign bus.SHIFT_CNT  = cnt_q;
    assign bus.SHIFT_DONE = done_q;
endmodule
